// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: load-use stalls, branch flushes, global hold and operand forwarding.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.

// Forwarding select for one ID source operand against the EX/MEM/WB scoreboard.
module hazard_fwd_sel #(
    parameter int AW = 4
) (
    input  logic [AW-1:0]        src,
    input  logic                 used,
    input  logic [2:0]           vld,
    input  logic [2:0][AW-1:0]   rd,
    output logic [1:0]           sel
);
    always_comb begin
        sel = 2'b00;
        // The all-ones register never forwards.
        if (used && (src != '1)) begin
            if      (vld[0] && (rd[0] == src)) sel = 2'b01;
            else if (vld[1] && (rd[1] == src)) sel = 2'b10;
            else if (vld[2] && (rd[2] == src)) sel = 2'b11;
        end
    end
endmodule

module hazard_scheduler #(
    parameter int AW     = 4,
    parameter int PERF_W = 16
) (
    input  logic          clk,
    input  logic          R,
    input  logic          ext_hold,
    input  logic [AW-1:0] ID_rn,
    input  logic [AW-1:0] ID_rm,
    input  logic [AW-1:0] ID_rd,
    input  logic          ID_use_rn,
    input  logic          ID_use_rm,
    input  logic          ID_use_rd,
    input  logic          ID_wr_en,
    input  logic          ID_load,
    input  logic          ID_branch,
    input  logic          ID_cond_true,
    output logic          PC_LE,
    output logic          IF_ID_LE,
    output logic          IF_ID_R,
    output logic          CU_S,
    output logic          pipe_en,
    output logic          PC_src,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic [1:0]    fwd_d
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN, LU_STALL, HOLD} state_t;

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] rd;
        logic          ld;
    } slot_t;

    state_t state, state_nx, ret, ret_nx;
    slot_t [2:0] sb;  // [0]=EX, [1]=MEM, [2]=WB
    slot_t ex_new;

    logic [2:0][AW-1:0] src;
    logic [2:0]         use_v;
    logic [2:0]         sb_vld;
    logic [2:0][AW-1:0] sb_rd;
    logic [2:0]         lu_src;
    logic [2:0][1:0]    fwd_sel;
    logic               freeze, lu_stall, br_take;

    assign src   = {ID_rd, ID_rm, ID_rn};
    assign use_v = {ID_use_rd, ID_use_rm, ID_use_rn};

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_src
            assign sb_vld[i] = sb[i].vld;
            assign sb_rd[i]  = sb[i].rd;
            assign lu_src[i] = use_v[i] && (src[i] != '1) && sb[0].vld && sb[0].ld
                               && (sb[0].rd == src[i]);
            hazard_fwd_sel #(.AW(AW)) u_fwd (
                .src  (src[i]),
                .used (use_v[i]),
                .vld  (sb_vld),
                .rd   (sb_rd),
                .sel  (fwd_sel[i])
            );
        end
    endgenerate

    assign fwd_a = R ? fwd_sel[0] : 2'b00;
    assign fwd_b = R ? fwd_sel[1] : 2'b00;
    assign fwd_d = R ? fwd_sel[2] : 2'b00;

    // The HOLD state itself keeps the pipe frozen for the cycle in which ext_hold drops.
    assign freeze = ext_hold || (state == HOLD);

    always_comb begin
        PC_LE    = 1'b1;
        IF_ID_LE = 1'b1;
        IF_ID_R  = 1'b0;
        CU_S     = 1'b0;
        pipe_en  = 1'b1;
        PC_src   = 1'b0;
        state_nx = state;
        ret_nx   = ret;
        lu_stall = 1'b0;
        br_take  = 1'b0;
        if (freeze) begin
            PC_LE    = 1'b0;
            IF_ID_LE = 1'b0;
            pipe_en  = 1'b0;
            state_nx = ext_hold ? HOLD : ret;
            if (state != HOLD) ret_nx = state;
        end else begin
            lu_stall = |lu_src;
            br_take  = ID_branch && ID_cond_true && !lu_stall;
            state_nx = lu_stall ? LU_STALL : RUN;
            if (lu_stall) begin
                PC_LE    = 1'b0;
                IF_ID_LE = 1'b0;
                CU_S     = 1'b1;
            end else if (br_take) begin
                PC_src  = 1'b1;
                IF_ID_R = 1'b1;
            end
        end
        if (!R) begin
            PC_LE    = 1'b0;
            IF_ID_LE = 1'b0;
            IF_ID_R  = 1'b1;
            CU_S     = 1'b1;
            pipe_en  = 1'b0;
            PC_src   = 1'b0;
            lu_stall = 1'b0;
            br_take  = 1'b0;
        end
    end

    always_comb begin
        ex_new     = '0;
        ex_new.vld = ID_wr_en && !CU_S;
        ex_new.rd  = ID_rd;
        ex_new.ld  = ID_load;
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state <= RUN;
            ret   <= RUN;
            sb    <= '0;
        end else begin
            state <= state_nx;
            ret   <= ret_nx;
            if (pipe_en) sb <= {sb[1], sb[0], ex_new};
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (br_take  && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule
